// File: rtl/bus_decode_ctrl.sv
// rtl/bus_decode_ctrl.sv - multiplexed-bus address latch, chip-select decoder and wait-state generator
//
// Ports:
//   CLK       in   clock, all state updates on the rising edge
//   RESET_N   in   asynchronous active-low reset
//   ALE       in   address latch enable, starts a new bus cycle from any state
//   IOM       in   1 = IO cycle, 0 = memory cycle (latched with the address)
//   RD_N      in   active-low read strobe
//   WR_N      in   active-low write strobe
//   A_HI      in   upper address bits
//   AD_LO     in   multiplexed low address/data bits
//   ERR_CLR   in   synchronous clear of ERR_CNT, wins over a same-cycle increment
//   ADDR_LAT  out  latched address
//   CS        out  one-hot registered chip selects (all zero on a miss)
//   READY     out  CPU ready, low only while wait states are inserted
//   BUS_ERR   out  single-cycle error pulse (decode miss, double strobe, strobe timeout)
//   ERR_CNT   out  saturating count of BUS_ERR pulses

module bus_decode_ctrl #(
  parameter int                          ADDR_W       = 20,
  parameter int                          NUM_REGIONS  = 4,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE  = {20'h00000, 20'h80000, 20'h01C00, 20'h0FF00},
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_LIMIT = {20'h7FFFF, 20'hFFFFF, 20'h01DFF, 20'h0FF0F},
  parameter logic [NUM_REGIONS-1:0]      REGION_IO    = 4'b0011,
  parameter logic [NUM_REGIONS*4-1:0]    REGION_WAIT  = {4'd0, 4'd1, 4'd2, 4'd0},
  parameter int                          TIMEOUT      = 16
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   ALE,
  input  logic                   IOM,
  input  logic                   RD_N,
  input  logic                   WR_N,
  input  logic [ADDR_W-9:0]      A_HI,
  input  logic [7:0]             AD_LO,
  input  logic                   ERR_CLR,
  output logic [ADDR_W-1:0]      ADDR_LAT,
  output logic [NUM_REGIONS-1:0] CS,
  output logic                   READY,
  output logic                   BUS_ERR,
  output logic [7:0]             ERR_CNT
);

  localparam int TCNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ADDR, CMD, WAIT, XFER} state_t;

  state_t                   state;
  logic                     iom_lat;
  logic [3:0]               wait_sel;
  logic [3:0]               wcnt;
  logic [TCNT_W-1:0]        tcnt;

  logic [ADDR_W-1:0]        cmp_addr;
  logic [NUM_REGIONS-1:0]   hit_cs;
  logic                     hit_any;
  logic [3:0]               hit_wait;
  logic                     rd_act;
  logic                     wr_act;
  logic                     timeout_hit;
  logic                     err_event;

  // Region match. IO cycles only carry a 16-bit port address, so the upper
  // latched bits are ignored. Scanning from the top index down lets the
  // lowest matching region overwrite any higher one.
  always_comb begin
    cmp_addr = ADDR_LAT;
    if (iom_lat) cmp_addr = ADDR_W'(ADDR_LAT[15:0]);
    hit_cs   = '0;
    hit_any  = 1'b0;
    hit_wait = 4'd0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (REGION_IO[i] == iom_lat &&
          cmp_addr >= REGION_BASE[i*ADDR_W +: ADDR_W] &&
          cmp_addr <= REGION_LIMIT[i*ADDR_W +: ADDR_W]) begin
        hit_cs    = '0;
        hit_cs[i] = 1'b1;
        hit_any   = 1'b1;
        hit_wait  = REGION_WAIT[i*4 +: 4];
      end
    end
  end

  assign rd_act      = ~RD_N;
  assign wr_act      = ~WR_N;
  assign timeout_hit = (tcnt == TCNT_W'(TIMEOUT - 1));

  // A new ALE pre-empts every error source in the same edge.
  always_comb begin
    err_event = 1'b0;
    if (!ALE) begin
      if (state == ADDR && !hit_any) err_event = 1'b1;
      if (state == CMD && rd_act && wr_act) err_event = 1'b1;
      if (state == CMD && !rd_act && !wr_act && timeout_hit) err_event = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      ADDR_LAT <= '0;
      iom_lat  <= 1'b0;
      CS       <= '0;
      READY    <= 1'b1;
      BUS_ERR  <= 1'b0;
      ERR_CNT  <= 8'd0;
      wait_sel <= 4'd0;
      wcnt     <= 4'd0;
      tcnt     <= '0;
    end else begin
      BUS_ERR <= err_event;
      if (ERR_CLR)
        ERR_CNT <= 8'd0;
      else if (err_event && ERR_CNT != 8'hFF)
        ERR_CNT <= ERR_CNT + 8'd1;

      if (ALE) begin
        ADDR_LAT <= {A_HI, AD_LO};
        iom_lat  <= IOM;
        CS       <= '0;
        READY    <= 1'b1;
        wcnt     <= 4'd0;
        tcnt     <= '0;
        state    <= ADDR;
      end else begin
        case (state)
          ADDR: begin
            CS       <= hit_cs;
            wait_sel <= hit_any ? hit_wait : 4'd0;
            tcnt     <= '0;
            state    <= CMD;
          end
          CMD: begin
            if (rd_act && wr_act) begin
              CS    <= '0;
              state <= XFER;
            end else if (rd_act || wr_act) begin
              if (wait_sel != 4'd0) begin
                READY <= 1'b0;
                wcnt  <= wait_sel;
                state <= WAIT;
              end else begin
                state <= XFER;
              end
            end else if (timeout_hit) begin
              CS    <= '0;
              state <= IDLE;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
          WAIT: begin
            if (wcnt == 4'd1) begin
              READY <= 1'b1;
              wcnt  <= 4'd0;
              state <= XFER;
            end else begin
              wcnt <= wcnt - 4'd1;
            end
          end
          XFER: begin
            if (RD_N && WR_N) begin
              CS    <= '0;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
